spi_master_fifo_wm: RTL and testbench
=====================================

SPI_MASTER_FIFO_WM -- requirements
Module: spi_master_fifo_wm

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the width of one entry in bits.
REQ-002 SHALL have parameter BUFFER_DEPTH, default 8, meaning the number of entries; legal range 2..1024, any value, not only powers of two.
REQ-003 SHALL have parameter LOG_BUFFER_DEPTH, default $clog2(BUFFER_DEPTH), meaning the pointer width; the count width is LOG_BUFFER_DEPTH+1.
REQ-004 Clock and reset: one clock clk_i; reset rst_ni is asynchronous and active-low.
REQ-005 clk_i  in  1  clock; all state updates on the rising edge.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 clr_i  in  1  synchronous flush.
REQ-008 valid_i  in  1  push request.
REQ-009 data_i  in  DATA_WIDTH  push data.
REQ-010 ready_o  out  1  space available.
REQ-011 valid_o  out  1  data available.
REQ-012 data_o  out  DATA_WIDTH  head entry.
REQ-013 ready_i  in  1  pop accept.
REQ-014 af_thr_i  in  LOG_BUFFER_DEPTH+1  almost-full threshold.
REQ-015 ae_thr_i  in  LOG_BUFFER_DEPTH+1  almost-empty threshold.
REQ-016 elements_o  out  LOG_BUFFER_DEPTH+1  current occupancy.
REQ-017 free_o  out  LOG_BUFFER_DEPTH+1  BUFFER_DEPTH minus elements_o.
REQ-018 almost_full_o  out  1  occupancy is at or above af_thr_i.
REQ-019 almost_empty_o  out  1  occupancy is at or below ae_thr_i.
REQ-020 ovf_o  out  1  sticky overflow flag.
REQ-021 ovf_clr_i  in  1  clears ovf_o.

Function
REQ-022 Push occurs when valid_i && ready_o; pop occurs when valid_o && ready_i.
REQ-023 ready_o = (elements != BUFFER_DEPTH), registered-state only; there is no combinational path from ready_i.
REQ-024 When the FIFO is full, a push is refused even if a pop happens in the same cycle.
REQ-025 valid_o = (elements != 0); data_o = storage[rd_ptr].
REQ-026 Latency is one cycle: a push into an empty FIFO gives valid_o=1 in the next cycle, with no same-cycle fall-through.
REQ-027 Occupancy update: push only gives +1; pop only gives -1; push and pop together, or neither, leave it unchanged.
REQ-028 Pointers advance by 1 on each push or pop and wrap from BUFFER_DEPTH-1 to 0, also for non-power-of-two depths.
REQ-029 almost_full_o and almost_empty_o are combinational from the registered count; a threshold of 0 means: AF is always 1, AE is 1 only when the FIFO is empty.
REQ-030 ovf_o sets on valid_i && !ready_o and stays set until ovf_clr_i or reset; if set and clear occur in the same cycle, set wins.
REQ-031 clr_i zeroes the pointers and the count next cycle and overrides any simultaneous push or pop; it does not clear ovf_o, and storage contents are untouched.
REQ-032 Threshold inputs are quasi-static; values above BUFFER_DEPTH behave as compares against the full count with no saturation.

Reset
REQ-033 On rst_ni low: pointers, count, ovf_o and storage reset to 0.
REQ-034 Resulting outputs on rst_ni low: valid_o=0, ready_o=1, data_o=0, elements_o=0, free_o=BUFFER_DEPTH.
REQ-035 A reset asserted mid-transfer discards all entries immediately (asynchronously).

Configuration
REQ-036 Macro SPI_FIFO_HWM_EN, when defined, adds output hwm_o (LOG_BUFFER_DEPTH+1), the peak occupancy since reset or since a hwm_clr_i input pulse.
REQ-037 hwm_o updates in the same cycle elements_o updates and is reset to 0.
REQ-038 hwm_clr_i loads hwm_o with the current elements_o.
REQ-039 Without SPI_FIFO_HWM_EN, the hwm_o and hwm_clr_i ports and all related logic are absent; all other behaviour is identical.

Structure
REQ-040 Package spi_master_pkg SHALL hold the FIFO depth and width defaults and a status struct {elements, free, almost_full, almost_empty, ovf}.
REQ-041 Sub-module spi_fifo_ptr SHALL be a modulo-BUFFER_DEPTH wrapping pointer with inc_i and clr_i, instantiated once for the read pointer and once for the write pointer.

Verification
REQ-042 DEPTH=8: push 8 words 0x1..0x8 with ready_i=0 -> ready_o=0 after the 8th push, elements_o=8, free_o=0; a 9th valid_i sets ovf_o=1.
REQ-043 DEPTH=5: stream 23 pushes and pops continuously with ready_i=1 -> output order equals input order, pointers wrap at 4->0, elements_o never exceeds 1.
REQ-044 Full FIFO with valid_i=1 and ready_i=1 for one cycle -> one pop, no push, elements_o=DEPTH-1, and the data pushed in that cycle is not stored.
REQ-045 af_thr_i=6, ae_thr_i=2, DEPTH=8: fill from 0 -> almost_empty_o=1 for counts 0..2, almost_full_o=1 for counts 6..8.
REQ-046 With 4 entries held, pulse clr_i together with a push -> next cycle elements_o=0, valid_o=0, ovf_o unchanged; then a push of 0xA5 -> data_o=0xA5.
REQ-047 SPI_FIFO_HWM_EN defined: fill to 7, drain to 2 -> hwm_o=7; pulse hwm_clr_i -> hwm_o=2; assert rst_ni mid-burst -> all outputs take their reset values.

Source files
------------

// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - shared defaults and status type for the SPI master FIFO
//
// Purpose : default FIFO geometry and the packed status record that the FIFO
//           assembles from its registered state.
// Contents: SPI_FIFO_WIDTH_DEF, SPI_FIFO_DEPTH_DEF, SPI_FIFO_CNT_MAX_W,
//           spi_fifo_status_t.
// Options : none (SPI_FIFO_HWM_EN is consumed by spi_master_fifo_wm only).

package spi_master_pkg;

  localparam int unsigned SPI_FIFO_WIDTH_DEF = 32;
  localparam int unsigned SPI_FIFO_DEPTH_DEF = 8;

  // Widest count that any legal depth (up to 1024) can need: 1024 itself
  // takes 11 bits. Status fields use this width so one type serves every
  // instance; the FIFO slices the fields down to its own count width.
  localparam int unsigned SPI_FIFO_CNT_MAX_W = 11;

  typedef struct packed {
    logic [SPI_FIFO_CNT_MAX_W-1:0] elements;
    logic [SPI_FIFO_CNT_MAX_W-1:0] free;
    logic                          almost_full;
    logic                          almost_empty;
    logic                          ovf;
  } spi_fifo_status_t;

endpackage

// File: rtl/spi_fifo_ptr.sv
// rtl/spi_fifo_ptr.sv - modulo-DEPTH wrapping FIFO pointer
//
// Purpose : pointer that steps by one on inc_i and wraps from DEPTH-1 to 0,
//           correct for depths that are not powers of two.
// Ports   : clk_i  - clock, rising edge
//           rst_ni - asynchronous active-low reset, pointer goes to 0
//           clr_i  - synchronous clear to 0, wins over inc_i
//           inc_i  - advance by one
//           ptr_o  - current pointer value
// Options : none.

module spi_fifo_ptr #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [PTR_W-1:0] ptr_o
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_o <= '0;
    end else if (clr_i) begin
      ptr_o <= '0;
    end else if (inc_i) begin
      ptr_o <= (ptr_o == LAST) ? '0 : ptr_o + PTR_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_fifo_wm.sv
// rtl/spi_master_fifo_wm.sv - SPI master FIFO with watermarks and sticky overflow
//
// Purpose : single-clock FIFO, valid/ready on both sides, one cycle latency,
//           occupancy/free counts, almost-full/almost-empty watermarks and a
//           sticky overflow flag.
// Ports   : clk_i, rst_ni (async active-low), clr_i (sync flush)
//           valid_i/data_i/ready_o   - push side
//           valid_o/data_o/ready_i   - pop side
//           af_thr_i, ae_thr_i       - watermark thresholds (quasi-static)
//           elements_o, free_o       - occupancy and free space
//           almost_full_o, almost_empty_o, ovf_o, ovf_clr_i
//           hwm_clr_i, hwm_o         - peak occupancy (only with the option)
// Options : SPI_FIFO_HWM_EN - adds the high-water-mark output hwm_o and its
//           clear input hwm_clr_i.

module spi_master_fifo_wm
  import spi_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = SPI_FIFO_WIDTH_DEF,
  parameter int unsigned BUFFER_DEPTH     = SPI_FIFO_DEPTH_DEF,
  parameter int unsigned LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clr_i,
  input  logic                      valid_i,
  input  logic [DATA_WIDTH-1:0]     data_i,
  output logic                      ready_o,
  output logic                      valid_o,
  output logic [DATA_WIDTH-1:0]     data_o,
  input  logic                      ready_i,
  input  logic [LOG_BUFFER_DEPTH:0] af_thr_i,
  input  logic [LOG_BUFFER_DEPTH:0] ae_thr_i,
  output logic [LOG_BUFFER_DEPTH:0] elements_o,
  output logic [LOG_BUFFER_DEPTH:0] free_o,
  output logic                      almost_full_o,
  output logic                      almost_empty_o,
`ifdef SPI_FIFO_HWM_EN
  input  logic                      hwm_clr_i,
  output logic [LOG_BUFFER_DEPTH:0] hwm_o,
`endif
  input  logic                      ovf_clr_i,
  output logic                      ovf_o
);

  localparam int unsigned CNT_W = LOG_BUFFER_DEPTH + 1;

  logic [CNT_W-1:0]            count_q;
  logic [CNT_W-1:0]            count_d;
  logic [LOG_BUFFER_DEPTH-1:0] rd_ptr;
  logic [LOG_BUFFER_DEPTH-1:0] wr_ptr;
  logic [DATA_WIDTH-1:0]       mem_q [BUFFER_DEPTH];
  logic                        ovf_q;
  logic                        push;
  logic                        pop;
  spi_fifo_status_t            status;

  // Everything in the status record is derived from registered state only,
  // so ready_o has no path from ready_i and a full FIFO refuses a push even
  // when a pop happens in the same cycle.
  always_comb begin
    status              = '0;
    status.elements     = SPI_FIFO_CNT_MAX_W'(count_q);
    status.free         = SPI_FIFO_CNT_MAX_W'(BUFFER_DEPTH) - SPI_FIFO_CNT_MAX_W'(count_q);
    // Thresholds are compared unsaturated: 0 keeps almost_full high and
    // limits almost_empty to the empty state; values above the depth simply
    // never (AF) or always (AE) match.
    status.almost_full  = (count_q >= af_thr_i);
    status.almost_empty = (count_q <= ae_thr_i);
    status.ovf          = ovf_q;
  end

  assign ready_o        = (status.free != '0);
  assign valid_o        = (status.elements != '0);
  assign elements_o     = status.elements[CNT_W-1:0];
  assign free_o         = status.free[CNT_W-1:0];
  assign almost_full_o  = status.almost_full;
  assign almost_empty_o = status.almost_empty;
  assign ovf_o          = status.ovf;
  assign data_o         = mem_q[rd_ptr];

  assign push = valid_i & ready_o;
  assign pop  = valid_o & ready_i;

  spi_fifo_ptr #(
    .DEPTH (BUFFER_DEPTH),
    .PTR_W (LOG_BUFFER_DEPTH)
  ) u_wr_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_i),
    .inc_i  (push),
    .ptr_o  (wr_ptr)
  );

  spi_fifo_ptr #(
    .DEPTH (BUFFER_DEPTH),
    .PTR_W (LOG_BUFFER_DEPTH)
  ) u_rd_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_i),
    .inc_i  (pop),
    .ptr_o  (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A flush leaves storage untouched, so the write is suppressed as well.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(BUFFER_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push && !clr_i) begin
      mem_q[wr_ptr] <= data_i;
    end
  end

  // Set wins over clear; the flush does not touch the flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
    end else if (valid_i && !ready_o) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr_i) begin
      ovf_q <= 1'b0;
    end
  end

`ifdef SPI_FIFO_HWM_EN
  // Tracks the next count so the peak moves in the same cycle as elements_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hwm_o <= '0;
    end else if (hwm_clr_i) begin
      hwm_o <= count_q;
    end else if (count_d > hwm_o) begin
      hwm_o <= count_d;
    end
  end
`endif

endmodule

// File: tb/tb_spi_master_fifo_wm.sv
// tb/tb_spi_master_fifo_wm.sv - self-checking bench for spi_master_fifo_wm

module tb_spi_master_fifo_wm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // depth 8 instance
  logic        v8 = 0, r8 = 0, c8 = 0, oc8 = 0, hc8 = 0;
  logic [31:0] d8 = '0;
  logic [3:0]  af8_thr = 4'd6, ae8_thr = 4'd2;
  logic        ready8_o, valid8_o, af8_o, ae8_o, ovf8_o;
  logic [31:0] data8_o;
  logic [3:0]  el8_o, free8_o;
`ifdef SPI_FIFO_HWM_EN
  logic [3:0]  hwm8_o;
`endif

  // depth 5 instance
  logic        v5 = 0, r5 = 0, c5 = 0, oc5 = 0, hc5 = 0;
  logic [7:0]  d5 = '0;
  logic [3:0]  af5_thr = 4'd3, ae5_thr = 4'd1;
  logic        ready5_o, valid5_o, af5_o, ae5_o, ovf5_o;
  logic [7:0]  data5_o;
  logic [3:0]  el5_o, free5_o;
`ifdef SPI_FIFO_HWM_EN
  logic [3:0]  hwm5_o;
`endif

  spi_master_fifo_wm #(.DATA_WIDTH(32), .BUFFER_DEPTH(8)) u8 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(c8), .valid_i(v8), .data_i(d8),
    .ready_o(ready8_o), .valid_o(valid8_o), .data_o(data8_o), .ready_i(r8),
    .af_thr_i(af8_thr), .ae_thr_i(ae8_thr), .elements_o(el8_o), .free_o(free8_o),
    .almost_full_o(af8_o), .almost_empty_o(ae8_o),
`ifdef SPI_FIFO_HWM_EN
    .hwm_clr_i(hc8), .hwm_o(hwm8_o),
`endif
    .ovf_clr_i(oc8), .ovf_o(ovf8_o)
  );

  spi_master_fifo_wm #(.DATA_WIDTH(8), .BUFFER_DEPTH(5)) u5 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(c5), .valid_i(v5), .data_i(d5),
    .ready_o(ready5_o), .valid_o(valid5_o), .data_o(data5_o), .ready_i(r5),
    .af_thr_i(af5_thr), .ae_thr_i(ae5_thr), .elements_o(el5_o), .free_o(free5_o),
    .almost_full_o(af5_o), .almost_empty_o(ae5_o),
`ifdef SPI_FIFO_HWM_EN
    .hwm_clr_i(hc5), .hwm_o(hwm5_o),
`endif
    .ovf_clr_i(oc5), .ovf_o(ovf5_o)
  );

  // reference models: contents as queues, flags as plain bits
  logic [31:0] q8[$];
  logic [7:0]  q5[$];
  bit          ovf8m = 0, ovf5m = 0;
  int          hwm8m = 0, hwm5m = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check8();
    int n = q8.size();
    chk("el8", el8_o, n);
    chk("free8", free8_o, 8 - n);
    chk("valid8", valid8_o, n != 0);
    chk("ready8", ready8_o, n != 8);
    chk("af8", af8_o, n >= int'(af8_thr));
    chk("ae8", ae8_o, n <= int'(ae8_thr));
    chk("ovf8", ovf8_o, ovf8m);
    if (n > 0) chk("data8", data8_o, q8[0]);
`ifdef SPI_FIFO_HWM_EN
    chk("hwm8", hwm8_o, hwm8m);
`endif
  endtask

  task automatic check5();
    int n = q5.size();
    chk("el5", el5_o, n);
    chk("free5", free5_o, 5 - n);
    chk("valid5", valid5_o, n != 0);
    chk("ready5", ready5_o, n != 5);
    chk("af5", af5_o, n >= int'(af5_thr));
    chk("ae5", ae5_o, n <= int'(ae5_thr));
    chk("ovf5", ovf5_o, ovf5m);
    if (n > 0) chk("data5", data5_o, q5[0]);
`ifdef SPI_FIFO_HWM_EN
    chk("hwm5", hwm5_o, hwm5m);
`endif
  endtask

  // one clock on the depth-8 instance with the inputs currently driven
  task automatic cyc8();
    int  n = q8.size();
    bit  full = (n == 8);
    @(posedge clk);
    if (v8 && full) ovf8m = 1;
    else if (oc8)   ovf8m = 0;
    if (c8) q8.delete();
    else begin
      if (r8 && n > 0)  void'(q8.pop_front());
      if (v8 && !full)  q8.push_back(d8);
    end
    if (hc8) hwm8m = n;
    else if (q8.size() > hwm8m) hwm8m = q8.size();
    #1;
    check8();
  endtask

  task automatic cyc5();
    int  n = q5.size();
    bit  full = (n == 5);
    @(posedge clk);
    if (v5 && full) ovf5m = 1;
    else if (oc5)   ovf5m = 0;
    if (c5) q5.delete();
    else begin
      if (r5 && n > 0)  void'(q5.pop_front());
      if (v5 && !full)  q5.push_back(d5);
    end
    if (hc5) hwm5m = n;
    else if (q5.size() > hwm5m) hwm5m = q5.size();
    #1;
    check5();
  endtask

  task automatic drv8(input logic v, input logic [31:0] d, input logic r,
                      input logic c, input logic oc);
    v8 = v; d8 = d; r8 = r; c8 = c; oc8 = oc; hc8 = 0;
    cyc8();
  endtask

  task automatic reset_models();
    q8.delete(); q5.delete();
    ovf8m = 0; ovf5m = 0; hwm8m = 0; hwm5m = 0;
  endtask

  initial begin
    // reset state
    #12;
    check8();
    chk("rst_data8", data8_o, 32'h0);
    check5();
    chk("rst_data5", data5_o, 8'h0);
    @(negedge clk) rst_n = 1'b1;

    // fill 0x1..0x8 without popping, watermarks 6/2 seen at every count
    for (int i = 1; i <= 8; i++) drv8(1, i, 0, 0, 0);
    chk("full_ready", ready8_o, 1'b0);
    chk("full_free", free8_o, 4'd0);
    drv8(1, 32'h9, 0, 0, 0);
    chk("ovf_set", ovf8_o, 1'b1);

    // full with push and pop together: only the pop happens
    drv8(1, 32'hDEAD, 1, 0, 0);
    chk("fullpp_el", el8_o, 4'd7);
    for (int i = 0; i < 7; i++) drv8(0, 0, 1, 0, 0);

    // flush with a simultaneous push, overflow flag kept
    for (int i = 0; i < 4; i++) drv8(1, 32'h10 + i, 0, 0, 0);
    drv8(1, 32'h77, 0, 1, 0);
    chk("clr_el", el8_o, 4'd0);
    chk("clr_ovf", ovf8_o, 1'b1);
    drv8(1, 32'hA5, 0, 0, 0);
    chk("clr_a5", data8_o, 32'hA5);
    drv8(0, 0, 1, 0, 0);

    // overflow set and clear in the same cycle: set wins
    for (int i = 0; i < 8; i++) drv8(1, $urandom, 0, 0, 0);
    drv8(1, 32'h1234, 0, 0, 1);
    chk("ovf_setwins", ovf8_o, 1'b1);
    drv8(0, 0, 0, 0, 1);
    chk("ovf_clr", ovf8_o, 1'b0);
    drv8(0, 0, 0, 1, 0);

    // zero thresholds, then thresholds above the depth
    af8_thr = 4'd0; ae8_thr = 4'd0;
    drv8(0, 0, 0, 0, 0);
    drv8(1, 32'h5, 0, 0, 0);
    af8_thr = 4'd15; ae8_thr = 4'd9;
    for (int i = 0; i < 8; i++) drv8(1, $urandom, 0, 0, 0);
    drv8(0, 0, 0, 1, 0);

`ifdef SPI_FIFO_HWM_EN
    // peak occupancy: fill to 7, drain to 2, then reload from the count
    hc8 = 1; cyc8(); hc8 = 0;
    for (int i = 0; i < 7; i++) drv8(1, $urandom, 0, 0, 0);
    for (int i = 0; i < 5; i++) drv8(0, 0, 1, 0, 0);
    chk("hwm_peak", hwm8_o, 4'd7);
    v8 = 0; r8 = 0; c8 = 0; oc8 = 0; hc8 = 1; cyc8(); hc8 = 0;
    chk("hwm_reload", hwm8_o, 4'd2);
`endif

    // randomized traffic on depth 8
    for (int blk = 0; blk < 6; blk++) begin
      int pv = $urandom_range(1, 3);
      int pr = $urandom_range(1, 3);
      af8_thr = 4'($urandom_range(0, 15));
      ae8_thr = 4'($urandom_range(0, 15));
      for (int k = 0; k < 50; k++) begin
        v8 = ($urandom_range(0, 3) < pv); d8 = $urandom;
        r8 = ($urandom_range(0, 3) < pr);
        c8 = ($urandom_range(0, 31) == 0);
        oc8 = ($urandom_range(0, 7) == 0);
        hc8 = ($urandom_range(0, 15) == 0);
        cyc8();
      end
    end

    // depth 5 stream: 23 words, push and pop every cycle
    v8 = 0; r8 = 0; c8 = 0; oc8 = 0; hc8 = 0;
    for (int i = 0; i < 24; i++) begin
      v5 = (i < 23); d5 = 8'($urandom); r5 = 1;
      cyc5();
      chk("stream_le1", el5_o <= 4'd1, 1'b1);
    end
    chk("stream_empty", valid5_o, 1'b0);

    // randomized traffic on depth 5
    for (int blk = 0; blk < 6; blk++) begin
      int pv = $urandom_range(1, 3);
      int pr = $urandom_range(1, 3);
      af5_thr = 4'($urandom_range(0, 15));
      ae5_thr = 4'($urandom_range(0, 15));
      for (int k = 0; k < 50; k++) begin
        v5 = ($urandom_range(0, 3) < pv); d5 = 8'($urandom);
        r5 = ($urandom_range(0, 3) < pr);
        c5 = ($urandom_range(0, 31) == 0);
        oc5 = ($urandom_range(0, 7) == 0);
        hc5 = ($urandom_range(0, 15) == 0);
        cyc5();
      end
    end
    v5 = 0; r5 = 0; c5 = 0; oc5 = 0; hc5 = 0;

    // reset in the middle of a burst takes effect without a clock edge
    for (int i = 0; i < 5; i++) drv8(1, $urandom, 0, 0, 0);
    drv8(1, 32'hCAFE, 0, 0, 0);
    v8 = 1; d8 = 32'hBEEF;
    rst_n = 1'b0;
    #1;
    reset_models();
    check8();
    chk("mid_rst_data8", data8_o, 32'h0);
    chk("mid_rst_ready8", ready8_o, 1'b1);
    check5();
    v8 = 0;
    @(negedge clk) rst_n = 1'b1;
    drv8(1, 32'h42, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
